dtc_window_vote: RTL and testbench
==================================

# dtc_window_vote

Temporal majority-vote stage downstream of the decision-tree classifier. Consumes one 7-bit class code per accepted sample over a valid/ready stream and counts how often each code bit is set across a fixed window. At the end of each window it emits a registered 7-bit code, with each bit set on strict majority, over a second valid/ready stream. This smooths per-sample classifier jitter before the result leaves the classifier subsystem.

## Interface
Parameters:
- WIN_LEN, 16: samples per window; legal range 2..255.
- CNT_W, $clog2(WIN_LEN+1): width of per-bit counters and sample counter (derived; do not override).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  in_pred holds a valid classifier output.
- in_ready  out  1  stage accepts a sample this cycle.
- in_pred  in  7  classifier class code.
- out_valid  out  1  window result is available.
- out_ready  in  1  consumer accepts the result.
- out_vote  out  7  majority-voted class code.
- out_nsamp  out  CNT_W  number of samples contributing to out_vote.

## Operation
- FSM states:
  - ACCUM: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Accept condition: in_valid & in_ready.
  - Each accept increments sample counter nsamp.
  - Each accept increments counter cnt[b] for every b where in_pred[b]=1.
- ACCUM -> EMIT on the accept that makes nsamp reach WIN_LEN.
  - On that edge, register out_vote[b] = (2*cnt_next[b] > nsamp_next), where cnt_next and nsamp_next include the current sample.
  - Ties give 0.
  - Register out_nsamp = nsamp_next.
- EMIT -> ACCUM on out_valid & out_ready.
  - On the same edge, clear all cnt[b] and nsamp to 0.
- In EMIT:
  - out_vote and out_nsamp stay stable until the handshake completes.
  - in_pred is ignored.
- Arithmetic:
  - Counters never exceed WIN_LEN, so no saturation or wrap is possible.
  - Compare width is CNT_W+1 bits.
- Reset values (all take effect on the first rising edge with rst=1):
  - state=ACCUM, all counters=0, out_valid=0, out_vote=0, out_nsamp=0.
  - in_ready=0 while rst=1.
- Reset mid-window or mid-EMIT discards partial counts and any pending result; nothing is emitted for that window.

## Timing
- Latency: out_valid rises 1 cycle after the edge that accepts the final sample of the window.
- Minimum window period: WIN_LEN+1 cycles.
  - WIN_LEN accept cycles plus 1 EMIT cycle with out_ready=1.
  - in_ready returns to 1 the cycle after the output handshake.
- Backpressure: out_ready low holds EMIT indefinitely; in_ready stays 0 for the whole stall.
- in_valid gaps in ACCUM only stretch the window; no sample is lost.
- Handshake rules:
  - No combinational path from out_ready to in_ready.
  - in_ready depends only on state and rst.

## Configuration
- DTC_VOTE_FLUSH_EN defined:
  - Adds input port flush (1 bit).
  - flush=1 in ACCUM with nsamp>0 (counting any sample accepted that cycle) forces ACCUM -> EMIT.
  - The threshold uses the actual nsamp, and out_nsamp reports it.
  - flush with nsamp=0 and no accept that cycle is ignored.
  - flush in EMIT is ignored.
- DTC_VOTE_FLUSH_EN undefined: no flush port; windows close only at WIN_LEN.

## Structure
- Shared package dtc_pkg:
  - CLASS_W=7, FEAT_W=8.
  - vote_state_e enum {ACCUM, EMIT}.
- Sub-module dtc_bit_counter, instantiated CLASS_W times.
  - Holds a CNT_W-bit counter with inc and clr inputs and synchronous rst.
- Top level holds the FSM, the sample counter and the vote compare.

## Test plan
- WIN_LEN=4; in_pred=7'b1011011 accepted 3 times, then 7'b0000000 once; out_ready=1 -> out_valid high 1 cycle after the 4th accept, out_vote=7'b1011011, out_nsamp=4.
- WIN_LEN=4; 2×7'b0111001 then 2×7'b0000111 (tie on every set bit) -> out_vote=7'b0000001 (bit0 set 4/4; all other bits 2/4 tie -> 0).
- out_ready held 0 for 10 cycles after EMIT entry with in_valid=1 -> in_ready=0, out_vote stable throughout; first new sample accepted the cycle after out_ready=1.
- rst asserted for 1 cycle after 3 of 4 samples -> out_valid stays 0; next 4 samples of 7'b0100001 produce out_vote=7'b0100001, out_nsamp=4.
- in_valid toggled 1/0 each cycle, WIN_LEN=16, all 7'b0011111 -> out_vote=7'b0011111 after 16 accepts, and nothing is emitted early.
- DTC_VOTE_FLUSH_EN, WIN_LEN=16: 3 samples of 7'b0110111 then flush -> out_nsamp=3, out_vote=7'b0110111; flush with nsamp=0 produces no output.

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared definitions for the decision-tree classifier subsystem.
// Optional build macro used by dtc_window_vote: DTC_VOTE_FLUSH_EN.
package dtc_pkg;

    localparam int CLASS_W = 7;
    localparam int FEAT_W  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } vote_state_e;

endpackage

// File: rtl/dtc_bit_counter.sv
// Per-bit occurrence counter for the window vote. Besides clearing, it
// exposes the count including a pending increment, so the voter can decide
// on the edge that accepts the final sample of a window.
module dtc_bit_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_inc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_inc_o = cnt_q + CNT_W'(inc_i);

    // Next count: clear wins; clear and increment never coincide in practice.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc_o;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dtc_window_vote.sv
// Temporal majority vote over a window of classifier outputs.
// Each code bit is voted set when it appears in strictly more than half
// of the window's samples; ties resolve to 0.
// Build macro DTC_VOTE_FLUSH_EN adds a flush input that closes a partial
// window early (only when it holds at least one sample).
module dtc_window_vote
    import dtc_pkg::*;
#(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = $clog2(WIN_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef DTC_VOTE_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CLASS_W-1:0] in_pred,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_vote,
    output logic [CNT_W-1:0]   out_nsamp
);

    localparam logic [CNT_W-1:0] WIN_CNT = CNT_W'(WIN_LEN);

    vote_state_e        state_q, state_d;
    logic [CNT_W-1:0]   nsamp_q, nsamp_d;
    logic [CNT_W-1:0]   nsamp_inc;
    logic [CLASS_W-1:0] vote_q, vote_d;
    logic [CNT_W-1:0]   onsamp_q, onsamp_d;
    logic [CLASS_W-1:0] vote_now;
    logic [CNT_W-1:0]   cnt_inc [CLASS_W];
    logic               accept;
    logic               flush_req;
    logic               close_win;
    logic               emit_done;

    // Handshake signals depend only on the state register and reset, so
    // there is no combinational path from out_ready to in_ready.
    assign in_ready  = (state_q == ACCUM) && !rst;
    assign out_valid = (state_q == EMIT);
    assign out_vote  = vote_q;
    assign out_nsamp = onsamp_q;

    assign accept    = in_valid && in_ready;
    assign nsamp_inc = nsamp_q + CNT_W'(accept);
    assign emit_done = (state_q == EMIT) && out_ready;

`ifdef DTC_VOTE_FLUSH_EN
    assign flush_req = flush && (nsamp_inc != '0);
`else
    assign flush_req = 1'b0;
`endif

    assign close_win = (state_q == ACCUM) &&
                       ((accept && (nsamp_inc == WIN_CNT)) || flush_req);

    // One counter per code bit plus its strict-majority compare, done at
    // CNT_W+1 bits so 2*count cannot overflow.
    generate
        for (genvar gi = 0; gi < CLASS_W; gi++) begin : g_bit
            dtc_bit_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc_i     (accept && in_pred[gi]),
                .clr_i     (emit_done),
                .cnt_inc_o (cnt_inc[gi])
            );
            assign vote_now[gi] = {cnt_inc[gi], 1'b0} > {1'b0, nsamp_inc};
        end
    endgenerate

    // Next-state logic: accumulate until the window closes, hold the
    // result until the consumer takes it, then start a fresh window.
    always_comb begin
        state_d  = state_q;
        nsamp_d  = nsamp_q;
        vote_d   = vote_q;
        onsamp_d = onsamp_q;
        case (state_q)
            ACCUM: begin
                nsamp_d = nsamp_inc;
                if (close_win) begin
                    state_d  = EMIT;
                    vote_d   = vote_now;
                    onsamp_d = nsamp_inc;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    nsamp_d = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // State, sample count and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACCUM;
            nsamp_q  <= '0;
            vote_q   <= '0;
            onsamp_q <= '0;
        end else begin
            state_q  <= state_d;
            nsamp_q  <= nsamp_d;
            vote_q   <= vote_d;
            onsamp_q <= onsamp_d;
        end
    end

endmodule

// File: tb/tb_dtc_window_vote.sv
// Scoreboard bench for dtc_window_vote (WIN_LEN=4). A cycle model predicts
// handshake levels and pushes each expected window result onto a queue;
// results are popped and compared when the DUT completes an output handshake.
module tb_dtc_window_vote;

    localparam int WL = 4;
    localparam int CW = $clog2(WL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_pred;
    logic          out_valid;
    logic          out_ready;
    logic [6:0]    out_vote;
    logic [CW-1:0] out_nsamp;

    always #5 clk = ~clk;

    dtc_window_vote #(
        .WIN_LEN (WL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DTC_VOTE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pred   (in_pred),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vote  (out_vote),
        .out_nsamp (out_nsamp)
    );

    typedef struct {
        logic [6:0] vote;
        int         n;
    } res_t;

    res_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         m_cnt [7];
    int         m_n;
    bit         m_emit;
    logic [6:0] last_vote;
    int         last_n;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic m_clear();
        for (int b = 0; b < 7; b++) m_cnt[b] = 0;
        m_n = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_pred = '0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'(0));
        check_eq("rst_out_vote", 32'(out_vote), 32'(0));
        check_eq("rst_out_nsamp", 32'(out_nsamp), 32'(0));
        rst = 1'b0;
        m_clear();
        m_emit = 1'b0;
        sb.delete();
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step(input bit v, input logic [6:0] p, input bit ordy, input bit fl);
        logic [6:0] vv;
        in_valid = v; in_pred = p; out_ready = ordy; flush = fl;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'(!m_emit));
        check_eq("out_valid", 32'(out_valid), 32'(m_emit));
        if (m_emit && sb.size() > 0) begin
            check_eq("out_vote", 32'(out_vote), 32'(sb[0].vote));
            check_eq("out_nsamp", 32'(out_nsamp), 32'(sb[0].n));
            if (ordy) begin
                last_vote = sb[0].vote;
                last_n    = sb[0].n;
                $display("window: vote=%b nsamp=%0d (dut vote=%b nsamp=%0d)",
                         sb[0].vote, sb[0].n, out_vote, out_nsamp);
                void'(sb.pop_front());
            end
        end
        if (m_emit) begin
            if (ordy) begin
                m_emit = 1'b0;
                m_clear();
            end
        end else begin
            if (v) begin
                m_n++;
                for (int b = 0; b < 7; b++) if (p[b]) m_cnt[b]++;
            end
            if ((v && m_n == WL) || (fl && m_n > 0)) begin
                for (int b = 0; b < 7; b++) vv[b] = (2 * m_cnt[b] > m_n);
                sb.push_back('{vv, m_n});
                m_emit = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        m_clear();
        m_emit = 1'b0;
        last_vote = '0;
        last_n = 0;
        do_reset();

        // Three majority samples and one zero sample.
        for (int i = 0; i < 3; i++) step(1'b1, 7'b1011011, 1'b1, 1'b0);
        step(1'b1, 7'b0000000, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_major_vote", 32'(last_vote), 32'(7'b1011011));
        check_eq("tp_major_n", 32'(last_n), 32'(4));

        // Ties on every bit except bit0.
        step(1'b1, 7'b0111001, 1'b1, 1'b0);
        step(1'b1, 7'b0111001, 1'b1, 1'b0);
        step(1'b1, 7'b0000111, 1'b1, 1'b0);
        step(1'b1, 7'b0000111, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_tie_vote", 32'(last_vote), 32'(7'b0000001));

        // Backpressure: hold the result for 10 cycles with input pending.
        for (int i = 0; i < 4; i++) step(1'b1, 7'b1100110, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 7'b0101010, 1'b0, 1'b0);
        step(1'b1, 7'b0101010, 1'b1, 1'b0);
        check_eq("tp_bp_vote", 32'(last_vote), 32'(7'b1100110));
        for (int i = 0; i < 4; i++) step(1'b1, 7'b0101010, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_bp_next", 32'(last_vote), 32'(7'b0101010));

        // Reset mid-window discards the partial result.
        for (int i = 0; i < 3; i++) step(1'b1, 7'b1111111, 1'b1, 1'b0);
        do_reset();
        step(1'b0, 7'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 7'b0100001, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_rst_vote", 32'(last_vote), 32'(7'b0100001));
        check_eq("tp_rst_n", 32'(last_n), 32'(4));

        // in_valid gaps only stretch the window.
        for (int i = 0; i < 16; i++) step(i % 2 == 0, 7'b0011111, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_gap_vote", 32'(last_vote), 32'(7'b0011111));

`ifdef DTC_VOTE_FLUSH_EN
        // Early close on flush with three samples.
        for (int i = 0; i < 3; i++) step(1'b1, 7'b0110111, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b1);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_flush_n", 32'(last_n), 32'(3));
        check_eq("tp_flush_vote", 32'(last_vote), 32'(7'b0110111));
        // Flush with an empty window is ignored.
        step(1'b0, 7'b0, 1'b1, 1'b1);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        // Flush together with the first accept closes a 1-sample window.
        step(1'b1, 7'b0000011, 1'b1, 1'b1);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("tp_flush_one", 32'(last_n), 32'(1));
        // Flush while holding a result is ignored.
        for (int i = 0; i < 4; i++) step(1'b1, 7'b1000000, 1'b0, 1'b0);
        step(1'b0, 7'b0, 1'b0, 1'b1);
        step(1'b0, 7'b0, 1'b1, 1'b0);
        step(1'b0, 7'b0, 1'b1, 1'b0);
`endif

        // Random traffic.
        for (int i = 0; i < 80; i++)
            step(1'($urandom), 7'($urandom), ($urandom % 4) != 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 7'b0, 1'b1, 1'b0);
        check_eq("sb_drained", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
